// File: rtl/mod_updown_counter_if.sv
// -----------------------------------------------------------------------------
// mod_updown_counter_if : control/status bundle of the modulo up/down counter.
// The master side drives the counting controls, the slave side (the counter)
// returns the count value and run status.
// Optional feature macro: MOD_UPDOWN_COUNTER_WRAP_CNT_EN adds the WRAPS output.
// -----------------------------------------------------------------------------
interface mod_updown_counter_if #(
   parameter int WIDTH = 3
);
   logic             EN;       // count enable
   logic             UP;       // 1 = count up, 0 = count down
   logic             LD;       // synchronous load of D
   logic [WIDTH-1:0] D;        // load value
   logic             START;    // start / restart request
   logic             ONESHOT;  // mode, sampled when START is accepted
   logic [WIDTH-1:0] Q;        // count value
   logic             TC;       // terminal count (combinational)
   logic             BUSY;     // high while running
   logic             DONE;     // high after a one-shot completion
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
   logic [7:0]       WRAPS;    // saturating free-run wrap counter
`endif

   modport master (
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
      input  WRAPS,
`endif
      output EN, UP, LD, D, START, ONESHOT,
      input  Q, TC, BUSY, DONE
   );

   modport slave (
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
      output WRAPS,
`endif
      input  EN, UP, LD, D, START, ONESHOT,
      output Q, TC, BUSY, DONE
   );
endinterface : mod_updown_counter_if

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter : modulo-MOD up/down counter with synchronous load, count
// enable and an IDLE/RUN/DONE run-control FSM (free-run or one-shot).
// Q always stays in 0..MOD-1; wrapping is modulo MOD, not 2**WIDTH.
// Optional feature macro: MOD_UPDOWN_COUNTER_WRAP_CNT_EN adds an 8-bit
// saturating count of free-run wraps on bus.WRAPS.
// -----------------------------------------------------------------------------
module mod_updown_counter #(
   parameter int WIDTH = 3,   // 2..16
   parameter int MOD   = 8    // 2..2**WIDTH
) (
   input  logic                  CK,
   input  logic                  R,
   mod_updown_counter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Widened by one bit so MOD == 2**WIDTH is still representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MOD - 1);

   state_t           state_q;
   logic             mode_q;     // 1 = one-shot, 0 = free-run
   logic [WIDTH-1:0] q_q;
   logic             busy_q;
   logic             done_q;
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
   logic [7:0]       wraps_q;
`endif

   logic [WIDTH-1:0] term_val;
   logic             at_term;
   logic [WIDTH-1:0] ld_val_d;
   logic [WIDTH-1:0] start_val_d;
   logic [WIDTH-1:0] q_step_d;

   // Terminal/load/preset/step values, all following the live UP input.
   always_comb begin
      term_val    = bus.UP ? Q_MAX : '0;
      at_term     = (q_q == term_val);
      ld_val_d    = ({1'b0, bus.D} < MOD_EXT) ? bus.D : Q_MAX;
      start_val_d = bus.UP ? '0 : Q_MAX;
      if (bus.UP) q_step_d = at_term ? '0    : q_q + 1'b1;
      else        q_step_d = at_term ? Q_MAX : q_q - 1'b1;
   end

   // Run-control FSM with count register and registered status outputs.
   // NOTE: every register here is assigned with <= so all of them update
   // from the same pre-edge values; blocking = would leak new values forward.
   always_ff @(posedge CK or posedge R) begin
      if (R) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         q_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
         wraps_q <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.START) begin
                  state_q <= ST_RUN;
                  mode_q  <= bus.ONESHOT;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  // A simultaneous load replaces the preset value.
                  q_q     <= bus.LD ? ld_val_d : start_val_d;
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
                  wraps_q <= '0;
`endif
               end else if (bus.LD) begin
                  q_q <= ld_val_d;
               end
            end
            ST_RUN: begin
               // Load wins over counting and never changes the state.
               if (bus.LD) begin
                  q_q <= ld_val_d;
               end else if (bus.EN) begin
                  if (at_term && mode_q) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     q_q <= q_step_d;
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
                     if (at_term && (wraps_q != 8'hFF)) wraps_q <= wraps_q + 8'd1;
`endif
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Output drive; TC is the only combinational output.
   always_comb begin
      bus.Q    = q_q;
      bus.BUSY = busy_q;
      bus.DONE = done_q;
      bus.TC   = busy_q & bus.EN & at_term;
   end

`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
   assign bus.WRAPS = wraps_q;
`endif

endmodule : mod_updown_counter

// File: tb/tb_mod_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_updown_counter : drives a MOD=8 and a MOD=6 counter (WIDTH=3) with the
// same stimulus and compares both against a behavioural model built on
// modular arithmetic. Directed phases first, then randomized traffic.
// Build with MOD_UPDOWN_COUNTER_WRAP_CNT_EN to also cover WRAPS saturation.
// -----------------------------------------------------------------------------
module tb_mod_updown_counter;
   localparam int W = 3;

   logic         ck = 1'b0;
   logic         rst;
   logic         en, up, ld, start, oneshot;
   logic [W-1:0] d;

   mod_updown_counter_if #(.WIDTH(W)) bus8 ();
   mod_updown_counter_if #(.WIDTH(W)) bus6 ();

   assign bus8.EN = en;  assign bus8.UP = up;  assign bus8.LD = ld;
   assign bus8.D  = d;   assign bus8.START = start;  assign bus8.ONESHOT = oneshot;
   assign bus6.EN = en;  assign bus6.UP = up;  assign bus6.LD = ld;
   assign bus6.D  = d;   assign bus6.START = start;  assign bus6.ONESHOT = oneshot;

   mod_updown_counter #(.WIDTH(W), .MOD(8)) dut8 (.CK(ck), .R(rst), .bus(bus8.slave));
   mod_updown_counter #(.WIDTH(W), .MOD(6)) dut6 (.CK(ck), .R(rst), .bus(bus6.slave));

   always #5 ck = ~ck;

   typedef struct {
      int q;
      bit run;
      bit done;
      bit os;
      int wraps;
   } model_t;

   model_t m[2];
   int     mods[2] = '{8, 6};
   int     total = 0;
   int     bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic model_t model_step(model_t s, int mod, bit en_i, bit up_i,
                                         bit ld_i, bit start_i, bit os_i, int d_i);
      int ldv;
      int term;
      ldv  = (d_i < mod) ? d_i : mod - 1;
      term = up_i ? mod - 1 : 0;
      if (!s.run) begin
         if (start_i) begin
            s.run   = 1'b1;
            s.done  = 1'b0;
            s.os    = os_i;
            s.wraps = 0;
            s.q     = ld_i ? ldv : (up_i ? 0 : mod - 1);
         end else if (ld_i) begin
            s.q = ldv;
         end
      end else if (ld_i) begin
         s.q = ldv;
      end else if (en_i) begin
         if (s.q == term && s.os) begin
            s.run  = 1'b0;
            s.done = 1'b1;
         end else begin
            if (s.q == term && s.wraps < 255) s.wraps++;
            s.q = (s.q + (up_i ? 1 : mod - 1)) % mod;
         end
      end
      return s;
   endfunction

   function automatic bit model_tc(model_t s, int mod);
      return s.run && en && (s.q == (up ? mod - 1 : 0));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) m[i] = '{q: 0, run: 1'b0, done: 1'b0, os: 1'b0, wraps: 0};
   endtask

   task automatic compare_all();
      check("m8.q",    32'(bus8.Q),    32'(m[0].q));
      check("m8.busy", 32'(bus8.BUSY), 32'(m[0].run));
      check("m8.done", 32'(bus8.DONE), 32'(m[0].done));
      check("m8.tc",   32'(bus8.TC),   32'(model_tc(m[0], mods[0])));
      check("m6.q",    32'(bus6.Q),    32'(m[1].q));
      check("m6.busy", 32'(bus6.BUSY), 32'(m[1].run));
      check("m6.done", 32'(bus6.DONE), 32'(m[1].done));
      check("m6.tc",   32'(bus6.TC),   32'(model_tc(m[1], mods[1])));
`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
      check("m8.wraps", 32'(bus8.WRAPS), 32'(m[0].wraps));
      check("m6.wraps", 32'(bus6.WRAPS), 32'(m[1].wraps));
`endif
   endtask

   // One clock: compare on the falling edge, advance the model on the rising edge.
   task automatic tick();
      @(negedge ck);
      compare_all();
      @(posedge ck);
      for (int i = 0; i < 2; i++)
         m[i] = model_step(m[i], mods[i], en, up, ld, start, oneshot, int'(d));
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
   task automatic do_reset();
      @(posedge ck);
      #3 rst = 1'b1;
      model_reset();
      #1 compare_all();
      @(posedge ck);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; start = 1'b0; oneshot = 1'b0; d = '0;
      model_reset();
      @(negedge ck);
      compare_all();
      @(posedge ck);
      #1 rst = 1'b0;

      // Idle: enable without START must not count.
      en = 1'b1;
      repeat (4) tick();

      // Free-run up, across a wrap.
      start = 1'b1; oneshot = 1'b0; up = 1'b1;
      tick();
      start = 1'b0;
      repeat (12) tick();

      // Reset mid-count, then free-run down (exercises MOD=6 preset of 5).
      do_reset();
      start = 1'b1; up = 1'b0;
      tick();
      start = 1'b0;
      repeat (10) tick();

      // One-shot up to completion, hold under EN, then restart.
      do_reset();
      start = 1'b1; oneshot = 1'b1; up = 1'b1;
      tick();
      start = 1'b0;
      repeat (12) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();

      // Load priority in RUN, including clamping of D=7.
      ld = 1'b1; d = 3'd3;
      tick();
      d = 3'd7;
      tick();
      ld = 1'b0;
      repeat (2) tick();

      // Load together with START in IDLE.
      do_reset();
      ld = 1'b1; start = 1'b1; oneshot = 1'b0; d = 3'd5;
      tick();
      ld = 1'b0; start = 1'b0;
      repeat (2) tick();

      // Enable gating and a direction flip.
      en = 1'b0; repeat (2) tick();
      en = 1'b1; tick();
      up = 1'b0; repeat (3) tick();
      up = 1'b1; repeat (2) tick();

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 3000; n++) begin
         en      = ($urandom % 4) != 0;
         if (($urandom % 8) == 0) up = ~up;
         ld      = ($urandom % 16) == 0;
         d       = W'($urandom);
         start   = ($urandom % 12) == 0;
         oneshot = $urandom % 2;
         if (($urandom % 300) == 0) do_reset();
         tick();
      end

`ifdef MOD_UPDOWN_COUNTER_WRAP_CNT_EN
      // Over 300 free-run wraps on the MOD=8 counter: WRAPS saturates.
      do_reset();
      ld = 1'b0; en = 1'b1; up = 1'b1; start = 1'b1; oneshot = 1'b0;
      tick();
      start = 1'b0;
      repeat (300 * 8 + 4) tick();
      @(negedge ck);
      check("wraps_sat", 32'(bus8.WRAPS), 32'd255);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mod_updown_counter
